// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: computes one MD op into a shadow register,
// then commits HI/LO after a fixed per-op latency. Optional MD_EARLY_DIV0_EN.
module md_sequencer #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbg_state_o
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] shadow_q, shadow_d;
  logic        done_q, done_d;

  // Arithmetic datapath, evaluated from the operands present at the start edge.
  logic [63:0] a_sx, b_sx;
  logic [63:0] prod_s, prod_u, madd_sum;
  logic        div_signed, div_zero;
  logic [31:0] dvd, dvs, quo, rem, quo_res, rem_res;
  logic [63:0] div_res;
  logic [7:0]  div_cnt;

  assign a_sx     = {{32{src_a[31]}}, src_a};
  assign b_sx     = {{32{src_b[31]}}, src_b};
  assign prod_s   = a_sx * b_sx;
  assign prod_u   = {32'd0, src_a} * {32'd0, src_b};
  assign madd_sum = {hi_q, lo_q} + prod_s;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign div_signed = (op == OP_DIV);
  assign div_zero   = (src_b == 32'd0);
  assign dvd        = (div_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign dvs        = div_zero ? 32'd1 :
                      ((div_signed && src_b[31]) ? (~src_b + 32'd1) : src_b);
  assign quo        = dvd / dvs;
  assign rem        = dvd % dvs;
  assign quo_res    = (div_signed && (src_a[31] ^ src_b[31])) ? (~quo + 32'd1) : quo;
  assign rem_res    = (div_signed && src_a[31]) ? (~rem + 32'd1) : rem;
  assign div_res    = div_zero ? {hi_q, lo_q} : {rem_res, quo_res};

`ifdef MD_EARLY_DIV0_EN
  assign div_cnt = div_zero ? 8'd0 : DIV_CNT;
`else
  assign div_cnt = DIV_CNT;
`endif

  // op_valid carries no ready: stall_req is the back-pressure, so any op
  // presented while RUN is dropped and the pipeline must not rely on it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT: begin
              shadow_d = prod_s;
              cnt_d    = MUL_CNT;
              state_d  = RUN;
            end
            OP_MULTU: begin
              shadow_d = prod_u;
              cnt_d    = MUL_CNT;
              state_d  = RUN;
            end
            OP_MADD: begin
              shadow_d = madd_sum;
              cnt_d    = MUL_CNT;
              state_d  = RUN;
            end
            OP_DIV, OP_DIVU: begin
              shadow_d = div_res;
              cnt_d    = div_cnt;
              state_d  = RUN;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          hi_d    = shadow_q[63:32];
          lo_d    = shadow_q[31:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      shadow_q <= 64'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign stall_req   = md_in_d & (busy | (op_valid & (op <= OP_MADD)));
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed vectors plus random ops, checked against a
// cycle-count reference model and an expected-result queue.
module tb_md_sequencer;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef MD_EARLY_DIV0_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = DIV_LAT;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        md_in_d = 1'b0;
  logic        busy, stall_req, done, dbg_state;
  logic [31:0] hi, lo;

  md_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .md_in_d(md_in_d),
    .busy(busy), .stall_req(stall_req), .done(done),
    .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_busy_left = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_pend = 64'd0;
  bit          md_rand = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = {h, l};
    case (o)
      3'd0: res = 64'(sa * sb);
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd4: res = {h, l} + 64'(sa * sb);
      3'd2: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd3: if (b != 0) res = {a % b, a / b};
      default: ;
    endcase
    return res;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] b);
    if (o == 3'd2 || o == 3'd3) return (b == 0) ? DIV0_LAT : DIV_LAT;
    return MUL_LAT;
  endfunction

  // Reference model: counts remaining busy cycles and holds architectural HI/LO.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_busy_left = 0; m_done = 1'b0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_done = 1'b1;
        end
      end else if (op_valid) begin
        if (op <= 3'd4) begin
          m_pend = ref_result(op, src_a, src_b, m_hi, m_lo);
          exp_q.push_back(m_pend);
          m_busy_left = ref_lat(op, src_b);
        end else if (op == 3'd5) m_hi = src_a;
        else if (op == 3'd6) m_lo = src_a;
      end
    end
  end

  // Monitor: per-cycle control checks, result pop on every done pulse.
  logic [63:0] mon_exp;
  initial forever begin
    @(negedge clk);
    check("busy", 64'(busy), 64'(m_busy_left > 0));
    check("done", 64'(done), 64'(m_done));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("stall_req", 64'(stall_req),
          64'(md_in_d & ((m_busy_left > 0) | (op_valid & (op <= 3'd4)))));
    if (done) begin
      if (exp_q.size() == 0) check("done_no_expect", 64'(done), 64'd0);
      else begin
        mon_exp = exp_q.pop_front();
        check("result", {hi, lo}, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    if (md_rand) md_in_d = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy_left != 0 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  // Counts DUT busy cycles right after an issue; leaves time at posedge+1.
  task automatic busy_len(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy || n >= 400) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [2:0] o;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    busy_len(n);
    check("mult_busy_len", 64'(n), 64'(MUL_LAT));
    check("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

    issue(3'd3, 32'd7, 32'd2);
    busy_len(n);
    check("divu_busy_len", 64'(n), 64'(DIV_LAT));
    check("divu_res", {hi, lo}, {32'd1, 32'd3});
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle();
    check("div_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    md_rand = 1'b0;
    md_in_d = 1'b1;
    issue(3'd0, 32'd4, 32'd5);
    wait_idle();
    tick();
    @(negedge clk);
    check("stall_after", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    md_rand = 1'b1;

    issue(3'd5, 32'd0, 32'd9);
    issue(3'd6, 32'd5, 32'd9);
    check("mt_regs", {hi, lo}, {32'd0, 32'd5});
    check("mt_busy", 64'(busy), 64'd0);
    issue(3'd4, 32'd2, 32'd3);
    wait_idle();
    check("madd_res", {hi, lo}, {32'd0, 32'd11});
    issue(3'd3, 32'd77, 32'd0);
    busy_len(n);
    check("div0_busy_len", 64'(n), 64'(DIV0_LAT));
    check("div0_res", {hi, lo}, {32'd0, 32'd11});

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    check("div_ovf", {hi, lo}, {32'd0, 32'h80000000});

    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (12) tick();

    issue(3'd0, 32'd1234, 32'd5678);
    issue(3'd3, 32'd9, 32'd2);
    wait_idle();
    check("ignored_op", {hi, lo}, 64'd7006652);

    for (int i = 0; i < 300; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(o, a, b);
      if ($urandom_range(0, 1) == 1) wait_idle();
      else repeat ($urandom_range(0, 12)) tick();
    end

    wait_idle();
    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
